// File: rtl/shmcp_pkg.sv
// Shared definitions for the 4-bit microcoded processor: loader FSM states,
// flag bit positions, branch condition codes and the idle ALU opcode.
package shmcp_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned COND_W = 3;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PART  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } ld_state_e;

  localparam logic [COND_W-1:0] COND_ALWAYS = 3'b000;
  localparam logic [COND_W-1:0] COND_Z      = 3'b001;
  localparam logic [COND_W-1:0] COND_NZ     = 3'b010;
  localparam logic [COND_W-1:0] COND_C      = 3'b011;
  localparam logic [COND_W-1:0] COND_NC     = 3'b100;
  localparam logic [COND_W-1:0] COND_N      = 3'b101;
  localparam logic [COND_W-1:0] COND_O      = 3'b110;
  localparam logic [COND_W-1:0] COND_NEVER  = 3'b111;

  localparam logic [OP_W-1:0] OP_IDLE = 2'b00;

endpackage

// File: rtl/operand_loader_if.sv
// Microcode strobes, shared bus and loader results between the sequencer
// (master) and the operand loader (slave).
interface operand_loader_if;
  import shmcp_pkg::*;

  logic              rs_a;
  logic              rs_b;
  logic              rs_f;
  logic              exec;
  logic [OP_W-1:0]   alu_op;
  logic [COND_W-1:0] cond;
  logic [DATA_W-1:0] bus;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] flags_q;
  logic [OP_W-1:0]   op_sel;
  logic              busy;
  logic              take;
  logic              err;

  modport master (
    output rs_a, rs_b, rs_f, exec, alu_op, cond, bus,
    input  a_q, b_q, flags_q, op_sel, busy, take, err
  );

  modport slave (
    input  rs_a, rs_b, rs_f, exec, alu_op, cond, bus,
    output a_q, b_q, flags_q, op_sel, busy, take, err
  );

endinterface

// File: rtl/operand_loader_cond_eval.sv
// Combinational branch-condition evaluator over the Z/C/O/N flag nibble;
// shared with the microsequencer.
module cond_eval
  import shmcp_pkg::*;
(
  input  logic [DATA_W-1:0] flags,
  input  logic [COND_W-1:0] cond,
  output logic              take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_ALWAYS: take = 1'b1;
      COND_Z:      take = flags[FLAG_Z];
      COND_NZ:     take = ~flags[FLAG_Z];
      COND_C:      take = flags[FLAG_C];
      COND_NC:     take = ~flags[FLAG_C];
      COND_N:      take = flags[FLAG_N];
      COND_O:      take = flags[FLAG_O];
      COND_NEVER:  take = 1'b0;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/operand_loader.sv
// Captures operands A/B and the flag nibble off the shared bus, issues a
// one-cycle op_sel pulse once both operands are held, and flags misuse.
module operand_loader
  import shmcp_pkg::*;
(
  input logic               clk,
  input logic               grst_n,
  input logic               lrst,
  operand_loader_if.slave   lb
);

  ld_state_e         state_q, state_d;
  logic              a_v_q, a_v_d;
  logic              b_v_q, b_v_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] flags_q, flags_d;
  logic [OP_W-1:0]   op_sel_q, op_sel_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              take_c;

  logic [1:0] n_strobe;
  logic       collide;
  logic       cap_a, cap_b, cap_f;
  logic       exec_ok;

  // A collision captures nothing; exec is still judged on its own.
  assign n_strobe = 2'(lb.rs_a) + 2'(lb.rs_b) + 2'(lb.rs_f);
  assign collide  = (n_strobe > 2'd1);
  assign cap_a    = lb.rs_a & ~collide;
  assign cap_b    = lb.rs_b & ~collide;
  assign cap_f    = lb.rs_f & ~collide;
  assign exec_ok  = lb.exec && (state_q == ST_READY) && (lb.alu_op != OP_IDLE);

  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      state_q <= ST_IDLE;
      a_v_q   <= 1'b0;
      b_v_q   <= 1'b0;
    end else if (lrst) begin
      state_q <= ST_IDLE;
      a_v_q   <= 1'b0;
      b_v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_v_q   <= a_v_d;
      b_v_q   <= b_v_d;
    end
  end

  // Leaving EXEC drops both valid bits; a strobe in that cycle starts the next pair.
  always_comb begin
    state_d = state_q;
    a_v_d   = a_v_q | cap_a;
    b_v_d   = b_v_q | cap_b;
    case (state_q)
      ST_EXEC: begin
        a_v_d   = cap_a;
        b_v_d   = cap_b;
        state_d = (cap_a || cap_b) ? ST_PART : ST_IDLE;
      end
      default: begin
        if (exec_ok) begin
          state_d = ST_EXEC;
        end else begin
          case ({a_v_d, b_v_d})
            2'b11:   state_d = ST_READY;
            2'b00:   state_d = ST_IDLE;
            default: state_d = ST_PART;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    flags_d  = flags_q;
    op_sel_d = OP_IDLE;
    busy_d   = 1'b0;
    err_d    = err_q;
    if (cap_a) a_d     = lb.bus;
    if (cap_b) b_d     = lb.bus;
    if (cap_f) flags_d = lb.bus;
    if (exec_ok) begin
      op_sel_d = lb.alu_op;
      busy_d   = 1'b1;
    end
    if (collide || (lb.exec && !exec_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      op_sel_q <= OP_IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (lrst) begin
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      op_sel_q <= OP_IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      flags_q  <= flags_d;
      op_sel_q <= op_sel_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (lb.cond),
    .take  (take_c)
  );

  assign lb.a_q     = a_q;
  assign lb.b_q     = b_q;
  assign lb.flags_q = flags_q;
  assign lb.op_sel  = op_sel_q;
  assign lb.busy    = busy_q;
  assign lb.err     = err_q;
  assign lb.take    = take_c;

endmodule
